// File: rtl/onn_pkg.sv
// Shared ONN constants and types used by the image loader, deserialiser and oscillator core.
package onn_pkg;

    localparam int unsigned FRAME_BITS = 60;
    localparam int unsigned N_NEUR     = 15;
    localparam int unsigned PH_W       = 4;
    localparam int unsigned CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } deser_state_e;

    typedef logic [FRAME_BITS-1:0] frame_t;

endpackage

// File: rtl/img_deser_if.sv
// Serial image link plus frame handoff between the deserialiser and the ONN core.
interface img_deser_if;
    import onn_pkg::*;

    logic                     data_in;
    logic                     load;
    logic                     frame_ready;
    logic [FRAME_BITS-1:0]    img_word;
    logic [N_NEUR*PH_W-1:0]   phase_init;
    logic                     frame_valid;
    logic                     short_err;
    logic                     overrun_err;
    logic [CNT_W-1:0]         bit_cnt;

    modport master (
        output data_in, load, frame_ready,
        input  img_word, phase_init, frame_valid, short_err, overrun_err, bit_cnt
    );

    modport slave (
        input  data_in, load, frame_ready,
        output img_word, phase_init, frame_valid, short_err, overrun_err, bit_cnt
    );

endinterface

// File: rtl/ser_shift.sv
// Serial-in shift register with burst tracking and a bit counter that saturates at WIDTH.
module ser_shift
    import onn_pkg::*;
#(
    parameter int unsigned WIDTH    = FRAME_BITS,
    parameter int unsigned CNT_BITS = CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                din,
    output logic [WIDTH-1:0]    sr,
    output logic [CNT_BITS-1:0] cnt,
    output logic                full,
    output logic                busy,
    output logic                start_c,
    output logic                short_c
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(WIDTH);

    logic                load_q;
    logic                take_c;
    logic [CNT_BITS-1:0] cnt_nxt;
    logic                busy_nxt;

    // A burst begins on a rising load; busy means a burst is mid-frame (1..WIDTH-1 bits).
    assign start_c = load & ~load_q;
    assign short_c = ~load & busy;
    assign take_c  = start_c | (load & busy);

    // Next count and burst-in-progress flag
    always_comb begin
        cnt_nxt  = cnt;
        busy_nxt = busy;
        if (start_c) begin
            cnt_nxt = CNT_BITS'(1);
        end else if (take_c) begin
            cnt_nxt = cnt + CNT_BITS'(1);
        end else if (short_c) begin
            cnt_nxt = '0;
        end
        if (take_c) begin
            busy_nxt = (cnt_nxt != CNT_MAX);
        end else if (short_c) begin
            busy_nxt = 1'b0;
        end
    end

    // Shift register and counters; full pulses the cycle after the last bit lands
    always_ff @(posedge clk) begin
        if (rst) begin
            sr     <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            full   <= 1'b0;
            load_q <= 1'b0;
        end else begin
            load_q <= load;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
            full   <= take_c && (cnt_nxt == CNT_MAX);
            if (take_c) begin
                sr <= {din, sr[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/img_deser.sv
// Image frame deserialiser: collects a serial burst into a frame and hands it to the ONN core.
module img_deser
    import onn_pkg::*;
#(
    parameter int unsigned FRAME_BITS = onn_pkg::FRAME_BITS,
    parameter int unsigned N_NEUR     = onn_pkg::N_NEUR,
    parameter int unsigned PH_W       = onn_pkg::PH_W
) (
    input  logic        sclk,
    input  logic        re,
    img_deser_if.slave  bus
);

    deser_state_e          state, state_nxt;
    logic [FRAME_BITS-1:0] sr;
    logic [CNT_W-1:0]      cnt;
    logic                  full, busy, start_c, short_c;

    logic [FRAME_BITS-1:0] img_word_q, img_word_nxt;
    logic                  frame_valid_q, frame_valid_nxt;
    logic                  short_err_q, short_err_nxt;
    logic                  overrun_err_q, overrun_err_nxt;
    logic                  accept_c;

    ser_shift #(
        .WIDTH    (FRAME_BITS),
        .CNT_BITS (CNT_W)
    ) u_shift (
        .clk     (sclk),
        .rst     (re),
        .load    (bus.load),
        .din     (bus.data_in),
        .sr      (sr),
        .cnt     (cnt),
        .full    (full),
        .busy    (busy),
        .start_c (start_c),
        .short_c (short_c)
    );

    assign accept_c = (state == ST_HOLD) && bus.frame_ready;

    // Next-state and output-register logic
    always_comb begin
        state_nxt       = state;
        img_word_nxt    = img_word_q;
        short_err_nxt   = short_err_q | short_c;
        overrun_err_nxt = overrun_err_q;
        case (state)
            ST_IDLE: begin
                if (full) begin
                    state_nxt    = ST_HOLD;
                    img_word_nxt = sr;
                end else if (start_c) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (full) begin
                    state_nxt    = ST_HOLD;
                    img_word_nxt = sr;
                end else if (short_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A frame finishing on the accept cycle replaces the held one seamlessly.
                if (accept_c) begin
                    if (full) begin
                        img_word_nxt = sr;
                    end else if (start_c || (busy && bus.load)) begin
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (full) begin
                    overrun_err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        frame_valid_nxt = (state_nxt == ST_HOLD);
    end

    // State and output registers
    always_ff @(posedge sclk) begin
        if (re) begin
            state         <= ST_IDLE;
            img_word_q    <= '0;
            frame_valid_q <= 1'b0;
            short_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            img_word_q    <= img_word_nxt;
            frame_valid_q <= frame_valid_nxt;
            short_err_q   <= short_err_nxt;
            overrun_err_q <= overrun_err_nxt;
        end
    end

    // Neuron i takes the i-th PH_W-bit field of the frame
    for (genvar i = 0; i < int'(N_NEUR); i++) begin : g_phase
        assign bus.phase_init[PH_W*i +: PH_W] = img_word_q[PH_W*i +: PH_W];
    end

    assign bus.img_word    = img_word_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.short_err   = short_err_q;
    assign bus.overrun_err = overrun_err_q;
    assign bus.bit_cnt     = cnt;

endmodule

// File: tb/tb_img_deser.sv
// Scoreboard bench for img_deser: frames are queued at send time, a monitor checks each presented frame.
module tb_img_deser;
    import onn_pkg::*;

    logic sclk = 1'b0;
    logic re;
    int   checks = 0;
    int   errors = 0;

    logic [FRAME_BITS-1:0] exp_q[$];
    logic                  fv_prev = 1'b0;
    logic [FRAME_BITS-1:0] img_prev = '0;

    localparam logic [59:0] F1 = 60'h880880880880880;
    localparam logic [59:0] FA = 60'h000080080080000;
    localparam logic [59:0] FB = 60'h010080080080100;
    localparam logic [59:0] FC = 60'h0F0F0F0F0F0F0F0;
    localparam logic [59:0] F6 = 60'h123456789ABCDEF;

    img_deser_if bus ();

    img_deser #(
        .FRAME_BITS (60),
        .N_NEUR     (15),
        .PH_W       (4)
    ) dut (
        .sclk (sclk),
        .re   (re),
        .bus  (bus.slave)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.load    = 1'b1;
            bus.data_in = v[i];
            tick();
        end
    endtask

    task automatic idle(input int n);
        bus.load    = 1'b0;
        bus.data_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic accept();
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;
        check("fv_after_accept", 64'(bus.frame_valid), 64'd0);
    endtask

    task automatic do_reset();
        re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    // Monitor: a new frame is presented on a frame_valid rise or a replacement while valid
    always @(negedge sclk) begin
        if (bus.frame_valid && (!fv_prev || bus.img_word != img_prev)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got %h expected none", bus.img_word);
            end else begin
                logic [FRAME_BITS-1:0] e;
                logic [N_NEUR*PH_W-1:0] ph;
                e = exp_q.pop_front();
                for (int i = 0; i < int'(N_NEUR); i++) ph[PH_W*i +: PH_W] = 4'((e >> (PH_W*i)) & 60'hF);
                check("sb_img_word", 64'(bus.img_word), 64'(e));
                check("sb_phase_init", 64'(bus.phase_init), 64'(ph));
            end
        end
        fv_prev  = bus.frame_valid;
        img_prev = bus.img_word;
    end

    initial begin
        re = 1'b1;
        bus.load = 1'b0;
        bus.data_in = 1'b0;
        bus.frame_ready = 1'b0;
        tick();
        tick();
        re = 1'b0;
        check("rst_fv", 64'(bus.frame_valid), 64'd0);
        check("rst_img", 64'(bus.img_word), 64'd0);
        check("rst_cnt", 64'(bus.bit_cnt), 64'd0);
        check("rst_short", 64'(bus.short_err), 64'd0);
        check("rst_ovr", 64'(bus.overrun_err), 64'd0);

        // Basic frame, one-cycle latency
        exp_q.push_back(F1);
        send({4'h0, F1}, 60);
        check("f1_cnt", 64'(bus.bit_cnt), 64'd60);
        check("f1_fv_early", 64'(bus.frame_valid), 64'd0);
        idle(1);
        check("f1_fv", 64'(bus.frame_valid), 64'd1);
        check("f1_img", 64'(bus.img_word), 64'(F1));
        check("f1_n0", 64'(bus.phase_init[3:0]), 64'd0);
        check("f1_n1", 64'(bus.phase_init[7:4]), 64'd8);
        check("f1_n2", 64'(bus.phase_init[11:8]), 64'd8);
        idle(2);
        check("f1_hold", 64'(bus.img_word), 64'(F1));
        accept();

        // Short burst
        send({4'h0, FC}, 37);
        check("short_cnt37", 64'(bus.bit_cnt), 64'd37);
        idle(1);
        check("short_err", 64'(bus.short_err), 64'd1);
        check("short_fv", 64'(bus.frame_valid), 64'd0);
        check("short_cnt", 64'(bus.bit_cnt), 64'd0);
        check("short_img", 64'(bus.img_word), 64'(F1));
        idle(2);

        // Overrun: B dropped while A unaccepted
        do_reset();
        exp_q.push_back(FA);
        send({4'h0, FA}, 60);
        idle(2);
        send({4'h0, FB}, 60);
        idle(1);
        check("ovr_err", 64'(bus.overrun_err), 64'd1);
        check("ovr_img", 64'(bus.img_word), 64'(FA));
        check("ovr_fv", 64'(bus.frame_valid), 64'd1);
        accept();

        // Accept on the cycle B completes
        do_reset();
        exp_q.push_back(FA);
        send({4'h0, FA}, 60);
        idle(1);
        exp_q.push_back(FB);
        send({4'h0, FB}, 60);
        bus.load = 1'b0;
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;
        check("swap_fv", 64'(bus.frame_valid), 64'd1);
        check("swap_img", 64'(bus.img_word), 64'(FB));
        check("swap_ovr", 64'(bus.overrun_err), 64'd0);
        idle(1);
        accept();

        // Reset mid-burst; tail becomes a short burst
        send({4'h0, FC}, 29);
        re = 1'b1;
        bus.load = 1'b1;
        bus.data_in = 1'b1;
        tick();
        re = 1'b0;
        check("mid_rst_fv", 64'(bus.frame_valid), 64'd0);
        check("mid_rst_img", 64'(bus.img_word), 64'd0);
        check("mid_rst_cnt", 64'(bus.bit_cnt), 64'd0);
        check("mid_rst_short", 64'(bus.short_err), 64'd0);
        check("mid_rst_ovr", 64'(bus.overrun_err), 64'd0);
        send({4'h0, FC} >> 30, 30);
        idle(1);
        check("tail_short", 64'(bus.short_err), 64'd1);
        check("tail_fv", 64'(bus.frame_valid), 64'd0);
        idle(2);

        // Over-long burst: extra bits ignored
        do_reset();
        exp_q.push_back(F6);
        send({4'hA, F6}, 64);
        idle(1);
        check("long_fv", 64'(bus.frame_valid), 64'd1);
        check("long_cnt", 64'(bus.bit_cnt), 64'd60);
        check("long_img", 64'(bus.img_word), 64'(F6));
        check("long_short", 64'(bus.short_err), 64'd0);
        accept();
        idle(3);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_deser.md
IMG_DESER -- requirements
Module: img_deser

Interface
REQ-001 Parameter FRAME_BITS, default 60: number of serial bits in one image frame.
REQ-002 Parameter N_NEUR, default 15: number of oscillators in the 3x5 array.
REQ-003 Parameter PH_W, default 4: initial-phase field width per neuron. FRAME_BITS SHALL equal N_NEUR*PH_W.
REQ-004 sclk  in  1: single clock; all state updates on the rising edge.
REQ-005 re  in  1: synchronous, active-high reset.
REQ-006 data_in  in  1: serial image bit from the image loader.
REQ-007 load  in  1: data_in is valid this cycle; high for one contiguous burst per frame.
REQ-008 img_word  out  FRAME_BITS: assembled frame, held stable while frame_valid is high.
REQ-009 phase_init  out  N_NEUR*PH_W: neuron i phase = img_word[PH_W*i+PH_W-1 : PH_W*i].
REQ-010 frame_valid  out  1: frame available to the ONN core.
REQ-011 frame_ready  in  1: ONN core accepts the frame when frame_valid and frame_ready are both high.
REQ-012 short_err  out  1: sticky; a burst ended before FRAME_BITS bits.
REQ-013 overrun_err  out  1: sticky; a complete frame was dropped because the previous one was not yet accepted.
REQ-014 bit_cnt  out  6: bits received in the current burst, for debug.

Function
REQ-015 Sample data_in only on cycles with load=1; data_in with load=0 is ignored.
REQ-016 Shift register update on each sampled bit: sr <= {data_in, sr[FRAME_BITS-1:1]}. The first received bit ends at sr[0], so a sender shifting out the LSB of its hex constant first reproduces that constant exactly.
REQ-017 FSM states: IDLE, SHIFT, HOLD.
REQ-018 IDLE: on load=1, capture the bit, set bit_cnt=1 and go to SHIFT.
REQ-019 SHIFT, load=1, bit_cnt<FRAME_BITS: capture the bit and increment bit_cnt.
REQ-020 SHIFT, the 60th bit captured: on the next edge, copy sr to img_word, assert frame_valid, and go to HOLD. Latency from the last load=1 cycle to frame_valid=1 is 1 cycle.
REQ-021 Bits with load=1 beyond FRAME_BITS in the same burst are ignored. bit_cnt saturates at FRAME_BITS.
REQ-022 SHIFT, load falls with bit_cnt<FRAME_BITS: discard the partial frame, set short_err, clear bit_cnt, return to IDLE. img_word is unchanged.
REQ-023 HOLD: img_word, phase_init and frame_valid stay stable until frame_ready=1.
REQ-024 Handshake: on the cycle frame_valid&frame_ready=1, frame_valid drops on the next edge and the FSM returns to IDLE. frame_ready while frame_valid=0 has no effect.
REQ-025 HOLD with load=1: continue receiving into sr (bit_cnt counts).
- If frame_ready arrives before the 60th bit, the new frame completes through the SHIFT path.
- If the 60th bit arrives while still unaccepted, drop the new frame, set overrun_err, and keep the held frame.
REQ-026 Simultaneous accept and 60th-bit completion: the new frame replaces img_word, frame_valid stays 1, and no overrun is flagged.
REQ-027 phase_init is combinational from img_word; no other output is combinational.

Reset
REQ-028 re=1 on any edge, including mid-burst or in HOLD: state=IDLE, sr=0, img_word=0, bit_cnt=0, frame_valid=0, short_err=0, overrun_err=0.
REQ-029 load during re=1 is ignored. A burst in progress when re falls is not resynchronised; its tail is treated as a new burst, which ends as short_err.

Structure
REQ-030 FRAME_BITS, N_NEUR, PH_W and the FSM state encoding SHALL live in a shared onn_pkg package, reused by the loader and the oscillator core.
REQ-031 One sub-module SHALL be used: ser_shift (serial-in shift register with enable plus saturating counter). The FSM and output registers stay in img_deser.

Verification
REQ-032 Send 60'h880880880880880 LSB-first with load high for 60 cycles -> one cycle later: frame_valid=1, img_word=60'h880880880880880, neuron0 phase=0, neuron1 phase=8, neuron2 phase=8.
REQ-033 Burst of 37 bits, then load low -> short_err=1, frame_valid=0, bit_cnt=0, img_word unchanged.
REQ-034 Hold frame_ready=0, send frame A=60'h000080080080000 then frame B=60'h010080080080100 -> img_word stays A, overrun_err=1. Then frame_ready=1 -> frame_valid=0 on the next edge.
REQ-035 frame_ready asserted on the same cycle frame B completes -> img_word=B, frame_valid stays 1, overrun_err=0.
REQ-036 Assert re at bit 30 of a burst -> all outputs 0 next cycle. The remaining 30 load cycles -> short_err=1, no frame_valid.
REQ-037 Burst of 64 load cycles -> frame_valid after bit 60, bit_cnt=60, bits 61-64 do not alter img_word.
